// File: rtl/amber128_pkg.sv
// amber128 shared package: capability widths, register file geometry,
// and the capability spill engine state encoding.
package amber128_pkg;

    localparam int C_XLEN        = 128;
    localparam int CAP_REG_AW    = 5;
    localparam int CAP_REG_COUNT = 32;
    localparam int CAP_BYTES     = C_XLEN / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cap_spill_state_e;

endpackage

// File: rtl/amber128_cap_spill.sv
// amber128_cap_spill: streams a contiguous range of capability registers
// to the store path as address/data beats with valid/ready backpressure.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               begin a spill (only honoured while idle)
//   first_reg_i/last_reg_i inclusive register range, sampled with start_i
//   base_addr_i           destination byte address (aligned down to 16 B)
//   busy_o, done_o        engine active / one-cycle completion pulse
//   cf_raddr_o/cf_rdata_i capability file read port (combinational data)
//   cf_we_o/cf_waddr_o/cf_wdata_o  capability file clear port
//   st_valid_o/st_ready_i/st_addr_o/st_data_o  store beat handshake
//
// Build option: define AMBER128_CAP_SPILL_CLEAR_EN to zero each register
// in the file as it is read out; otherwise the file is never written.
module amber128_cap_spill
    import amber128_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [CAP_REG_AW-1:0] first_reg_i,
    input  logic [CAP_REG_AW-1:0] last_reg_i,
    input  logic [ADDR_W-1:0]     base_addr_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CAP_REG_AW-1:0] cf_raddr_o,
    input  logic [C_XLEN-1:0]     cf_rdata_i,
    output logic                  cf_we_o,
    output logic [CAP_REG_AW-1:0] cf_waddr_o,
    output logic [C_XLEN-1:0]     cf_wdata_o,
    output logic                  st_valid_o,
    input  logic                  st_ready_i,
    output logic [ADDR_W-1:0]     st_addr_o,
    output logic [C_XLEN-1:0]     st_data_o
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]            state_q, state_d;
    logic [CAP_REG_AW-1:0] idx_q, idx_d;
    logic [CAP_REG_AW-1:0] last_q, last_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    // Set once the final register of the range sits in the buffer.
    logic                  all_q, all_d;
    logic                  vld_q, vld_d;
    logic [ADDR_W-1:0]     saddr_q, saddr_d;
    logic [C_XLEN-1:0]     sdata_q, sdata_d;

    logic in_run;
    logic hs;
    logic load;

    // Alignment discards the low address bits.
    logic unused_addr_lo;
    assign unused_addr_lo = ^base_addr_i[3:0];

    assign in_run = (state_q == ST_RUN);
    assign hs     = vld_q & st_ready_i;
    // Skid buffer refills when empty or when its beat leaves this cycle.
    assign load   = in_run & ~all_q & (~vld_q | hs);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        addr_d  = addr_q;
        all_d   = all_q;
        vld_d   = vld_q;
        saddr_d = saddr_q;
        sdata_d = sdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    idx_d  = first_reg_i;
                    last_d = last_reg_i;
                    addr_d = {base_addr_i[ADDR_W-1:4], 4'b0000};
                    all_d  = 1'b0;
                    if (first_reg_i > last_reg_i) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (load) begin
                    vld_d   = 1'b1;
                    saddr_d = addr_q;
                    sdata_d = cf_rdata_i;
                    addr_d  = addr_q + ADDR_W'(CAP_BYTES);
                    if (idx_q == last_q) begin
                        all_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (hs) begin
                    vld_d = 1'b0;
                end
                // No load once all_q is set, so this is the last beat.
                if (hs && all_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            addr_q  <= '0;
            all_q   <= 1'b0;
            vld_q   <= 1'b0;
            saddr_q <= '0;
            sdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            all_q   <= all_d;
            vld_q   <= vld_d;
            saddr_q <= saddr_d;
            sdata_q <= sdata_d;
        end
    end

    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = (state_q == ST_DONE);
    assign cf_raddr_o = in_run ? idx_q : '0;
    assign cf_wdata_o = '0;
    assign st_valid_o = vld_q;
    assign st_addr_o  = saddr_q;
    assign st_data_o  = sdata_q;

`ifdef AMBER128_CAP_SPILL_CLEAR_EN
    assign cf_we_o    = load;
    assign cf_waddr_o = in_run ? idx_q : '0;
`else
    assign cf_we_o    = 1'b0;
    assign cf_waddr_o = '0;
`endif

endmodule

// File: tb/tb_amber128_cap_spill.sv
// Directed testbench for amber128_cap_spill with a behavioural
// capability file and hand-computed expected beats.
module tb_amber128_cap_spill;
    import amber128_pkg::*;

    localparam int AW = 64;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [CAP_REG_AW-1:0] first_reg;
    logic [CAP_REG_AW-1:0] last_reg;
    logic [AW-1:0]         base_addr;
    logic                  busy;
    logic                  done;
    logic [CAP_REG_AW-1:0] cf_raddr;
    logic [C_XLEN-1:0]     cf_rdata;
    logic                  cf_we;
    logic [CAP_REG_AW-1:0] cf_waddr;
    logic [C_XLEN-1:0]     cf_wdata;
    logic                  st_valid;
    logic                  st_ready;
    logic [AW-1:0]         st_addr;
    logic [C_XLEN-1:0]     st_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    amber128_cap_spill #(.ADDR_W(AW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .first_reg_i (first_reg),
        .last_reg_i  (last_reg),
        .base_addr_i (base_addr),
        .busy_o      (busy),
        .done_o      (done),
        .cf_raddr_o  (cf_raddr),
        .cf_rdata_i  (cf_rdata),
        .cf_we_o     (cf_we),
        .cf_waddr_o  (cf_waddr),
        .cf_wdata_o  (cf_wdata),
        .st_valid_o  (st_valid),
        .st_ready_i  (st_ready),
        .st_addr_o   (st_addr),
        .st_data_o   (st_data)
    );

    // Behavioural capability file
    logic [C_XLEN-1:0]     regs [CAP_REG_COUNT];
    logic                  pl_we = 1'b0;
    logic [CAP_REG_AW-1:0] pl_idx = '0;
    logic [C_XLEN-1:0]     pl_val = '0;
    int                    we_cnt = 0;

    assign cf_rdata = regs[cf_raddr];

    always @(posedge clk) begin
        if (pl_we) regs[pl_idx] <= pl_val;
        else if (cf_we) regs[cf_waddr] <= cf_wdata;
        if (cf_we) we_cnt <= we_cnt + 1;
    end

    // Results of the most recent collect()
    logic [AW-1:0]     b_addr [$];
    logic [C_XLEN-1:0] b_data [$];
    int                b_cyc  [$];
    int done_cyc, done_cnt, end_cyc, vld_cyc, stall_cnt, stall_viol;
    int timed_out;
    logic busy_at1;

    task automatic preload();
        for (int i = 0; i < CAP_REG_COUNT; i++) begin
            @(negedge clk);
            pl_we  = 1'b1;
            pl_idx = CAP_REG_AW'(i);
            pl_val = C_XLEN'(32'hA0 + i);
        end
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    // Drives start_i during cycle 0.
    task automatic start_spill(input logic [CAP_REG_AW-1:0] f,
                               input logic [CAP_REG_AW-1:0] l,
                               input logic [AW-1:0] base);
        @(negedge clk);
        start     = 1'b1;
        first_reg = f;
        last_reg  = l;
        base_addr = base;
        st_ready  = 1'b0;
    endtask

    // Observes cycles 1.. at negedge; mode 0 = ready high, 1 = toggling.
    task automatic collect(input int mode, input bit hold_start);
        logic          stall_prev;
        logic [AW-1:0] pa;
        logic [C_XLEN-1:0] pd;
        b_addr.delete(); b_data.delete(); b_cyc.delete();
        done_cyc = -1; done_cnt = 0; end_cyc = -1; vld_cyc = 0;
        stall_cnt = 0; stall_viol = 0; timed_out = 1;
        stall_prev = 1'b0; pa = '0; pd = '0; busy_at1 = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 1) begin
                busy_at1  = busy;
                start     = hold_start;
                first_reg = '0;
                last_reg  = 5'd31;
                base_addr = '0;
            end
            st_ready = (mode == 0) ? 1'b1 : ((k % 2) == 0);
            if (stall_prev && (!st_valid || st_addr !== pa || st_data !== pd))
                stall_viol++;
            stall_prev = 1'b0;
            if (st_valid) begin
                vld_cyc++;
                if (st_ready) begin
                    b_addr.push_back(st_addr);
                    b_data.push_back(st_data);
                    b_cyc.push_back(k);
                end else begin
                    stall_cnt++;
                    stall_prev = 1'b1;
                    pa = st_addr;
                    pd = st_data;
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = k;
                start = 1'b0;
            end
            if (done_cnt > 0 && !busy) begin
                end_cyc = k;
                timed_out = 0;
                break;
            end
        end
        start    = 1'b0;
        st_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; st_ready = 1'b0;
        first_reg = '0; last_reg = '0; base_addr = '0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
        checks++; if (st_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", st_valid); end
        checks++; if (st_addr !== '0) begin errors++; $display("FAIL rst_addr got %h want 0", st_addr); end
        checks++; if (st_data !== '0) begin errors++; $display("FAIL rst_data got %h want 0", st_data); end
        checks++; if (cf_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", cf_we); end
        checks++; if (cf_raddr !== '0) begin errors++; $display("FAIL rst_raddr got %h want 0", cf_raddr); end
        checks++; if (cf_waddr !== '0) begin errors++; $display("FAIL rst_waddr got %h want 0", cf_waddr); end
        checks++; if (cf_wdata !== '0) begin errors++; $display("FAIL rst_wdata got %h want 0", cf_wdata); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [AW-1:0]     ea [4];
        logic [C_XLEN-1:0] ed [4];
        ea = '{64'h1000, 64'h1010, 64'h1020, 64'h1030};
        ed = '{128'hA1, 128'hA2, 128'hA3, 128'hA4};
        preload();
        start_spill(5'd1, 5'd4, 64'h1000);
        collect(0, 1'b0);
        checks++; if (timed_out != 0) begin errors++; $display("FAIL basic_timeout got %0d want 0", timed_out); end
        checks++; if (busy_at1 !== 1'b1) begin errors++; $display("FAIL basic_busy1 got %b want 1", busy_at1); end
        checks++; if (b_addr.size() != 4) begin errors++; $display("FAIL basic_count got %0d want 4", b_addr.size()); end
        for (int i = 0; i < 4 && i < b_addr.size(); i++) begin
            checks++; if (b_addr[i] !== ea[i]) begin errors++; $display("FAIL basic_addr%0d got %h want %h", i, b_addr[i], ea[i]); end
            checks++; if (b_data[i] !== ed[i]) begin errors++; $display("FAIL basic_data%0d got %h want %h", i, b_data[i], ed[i]); end
            checks++; if (b_cyc[i] != 2 + i) begin errors++; $display("FAIL basic_cyc%0d got %0d want %0d", i, b_cyc[i], 2 + i); end
        end
        checks++; if (done_cyc != 6) begin errors++; $display("FAIL basic_done_cyc got %0d want 6", done_cyc); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_cnt got %0d want 1", done_cnt); end
        checks++; if (end_cyc != 7) begin errors++; $display("FAIL basic_idle_cyc got %0d want 7", end_cyc); end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0]     ea [4];
        logic [C_XLEN-1:0] ed [4];
        ea = '{64'h1000, 64'h1010, 64'h1020, 64'h1030};
        ed = '{128'hA1, 128'hA2, 128'hA3, 128'hA4};
        preload();
        start_spill(5'd1, 5'd4, 64'h1000);
        collect(1, 1'b1);
        checks++; if (timed_out != 0) begin errors++; $display("FAIL bp_timeout got %0d want 0", timed_out); end
        checks++; if (b_addr.size() != 4) begin errors++; $display("FAIL bp_count got %0d want 4", b_addr.size()); end
        for (int i = 0; i < 4 && i < b_addr.size(); i++) begin
            checks++; if (b_addr[i] !== ea[i]) begin errors++; $display("FAIL bp_addr%0d got %h want %h", i, b_addr[i], ea[i]); end
            checks++; if (b_data[i] !== ed[i]) begin errors++; $display("FAIL bp_data%0d got %h want %h", i, b_data[i], ed[i]); end
        end
        checks++; if (stall_cnt == 0) begin errors++; $display("FAIL bp_stalls got %0d want >0", stall_cnt); end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stable got %0d want 0", stall_viol); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_cnt got %0d want 1", done_cnt); end
    endtask

    task automatic test_ranges();
        preload();
        start_spill(5'd5, 5'd2, 64'h2000);
        collect(0, 1'b0);
        checks++; if (done_cyc != 1) begin errors++; $display("FAIL empty_done_cyc got %0d want 1", done_cyc); end
        checks++; if (vld_cyc != 0) begin errors++; $display("FAIL empty_valid got %0d want 0", vld_cyc); end
        checks++; if (end_cyc != 2) begin errors++; $display("FAIL empty_idle_cyc got %0d want 2", end_cyc); end
        start_spill(5'd7, 5'd7, 64'h3008);
        collect(0, 1'b0);
        checks++; if (b_addr.size() != 1) begin errors++; $display("FAIL single_count got %0d want 1", b_addr.size()); end
        if (b_addr.size() > 0) begin
            checks++; if (b_addr[0] !== 64'h3000) begin errors++; $display("FAIL single_addr got %h want 3000", b_addr[0]); end
            checks++; if (b_data[0] !== 128'hA7) begin errors++; $display("FAIL single_data got %h want a7", b_data[0]); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL single_done_cnt got %0d want 1", done_cnt); end
    endtask

    task automatic test_wrap();
        preload();
        start_spill(5'd1, 5'd2, 64'hFFFF_FFFF_FFFF_FFF7);
        collect(0, 1'b0);
        checks++; if (b_addr.size() != 2) begin errors++; $display("FAIL wrap_count got %0d want 2", b_addr.size()); end
        if (b_addr.size() == 2) begin
            checks++; if (b_addr[0] !== 64'hFFFF_FFFF_FFFF_FFF0) begin errors++; $display("FAIL wrap_addr0 got %h want fffffffffffffff0", b_addr[0]); end
            checks++; if (b_addr[1] !== 64'h0) begin errors++; $display("FAIL wrap_addr1 got %h want 0", b_addr[1]); end
            checks++; if (b_data[1] !== 128'hA2) begin errors++; $display("FAIL wrap_data1 got %h want a2", b_data[1]); end
        end
    endtask

    task automatic test_reset_mid();
        int dn;
        preload();
        start_spill(5'd1, 5'd4, 64'h1000);
        @(negedge clk); start = 1'b0; st_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        checks++; if (st_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", st_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
        checks++; if (st_addr !== '0) begin errors++; $display("FAIL rmid_addr got %h want 0", st_addr); end
        rst = 1'b0; st_ready = 1'b0;
        dn = (done === 1'b1) ? 1 : 0;
        repeat (5) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        checks++; if (dn != 0) begin errors++; $display("FAIL rmid_no_done got %0d want 0", dn); end
        preload();
        start_spill(5'd1, 5'd4, 64'h1000);
        collect(0, 1'b0);
        checks++; if (b_addr.size() != 4) begin errors++; $display("FAIL rmid_restart_count got %0d want 4", b_addr.size()); end
        if (b_addr.size() == 4) begin
            checks++; if (b_data[3] !== 128'hA4) begin errors++; $display("FAIL rmid_restart_data got %h want a4", b_data[3]); end
            checks++; if (b_addr[3] !== 64'h1030) begin errors++; $display("FAIL rmid_restart_addr got %h want 1030", b_addr[3]); end
        end
    endtask

    task automatic test_clear();
        int w0;
        logic [C_XLEN-1:0] e;
        preload();
        @(negedge clk);
        w0 = we_cnt;
        start_spill(5'd1, 5'd3, 64'h4000);
        collect(0, 1'b0);
        @(negedge clk);
        checks++; if (b_data.size() != 3) begin errors++; $display("FAIL clr_count got %0d want 3", b_data.size()); end
        for (int i = 1; i <= 3; i++) begin
`ifdef AMBER128_CAP_SPILL_CLEAR_EN
            e = '0;
`else
            e = C_XLEN'(32'hA0 + i);
`endif
            checks++; if (regs[i] !== e) begin errors++; $display("FAIL clr_reg%0d got %h want %h", i, regs[i], e); end
        end
        checks++; if (regs[4] !== 128'hA4) begin errors++; $display("FAIL clr_reg4 got %h want a4", regs[4]); end
`ifdef AMBER128_CAP_SPILL_CLEAR_EN
        checks++; if (we_cnt - w0 != 3) begin errors++; $display("FAIL clr_we_cnt got %0d want 3", we_cnt - w0); end
`else
        checks++; if (we_cnt != 0) begin errors++; $display("FAIL clr_we_cnt got %0d want 0", we_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_ranges();
        test_wrap();
        test_reset_mid();
        test_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
